// File: rtl/alu_cmd_driver.sv
// ---------------------------------------------------------------------------
// alu_cmd_driver
//   Initiator for the 8-bit combinational ALU interface. Takes register-style
//   commands (rd, rs1, rs2/imm, op), reads operands from a small register
//   file, drives registered operands/opcode to the external ALU, captures the
//   result one cycle later, writes it back and returns it on a response port.
//
// Ports
//   clk, rst_n              clock (rising edge), asynchronous active-low reset
//   cmd_valid/cmd_ready     command handshake
//   cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_use_imm, cmd_imm   command fields
//   alu_a, alu_b, alu_op    registered operands/opcode to the ALU
//   alu_res                 combinational ALU result
//   rsp_valid/rsp_ready     response handshake
//   rsp_data, rsp_rd, rsp_zero   captured result, destination, zero flag
// ---------------------------------------------------------------------------
module alu_cmd_driver #(
  parameter int DATA_W   = 8,
  parameter int NUM_REGS = 4,
  parameter int REG_AW   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [REG_AW-1:0] cmd_rd,
  input  logic [REG_AW-1:0] cmd_rs1,
  input  logic [REG_AW-1:0] cmd_rs2,
  input  logic              cmd_use_imm,
  input  logic [DATA_W-1:0] cmd_imm,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [2:0]        alu_op,
  input  logic [DATA_W-1:0] alu_res,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [REG_AW-1:0] rsp_rd,
  output logic              rsp_zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t              state_reg, state_next;
  logic [REG_AW-1:0]   rd_reg;
  logic [DATA_W-1:0]   rf_reg [NUM_REGS];
  logic [NUM_REGS-1:0] wr_en;
  logic                cmd_fire;

  assign cmd_fire = cmd_valid && cmd_ready;

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cmd_ready  = 1'b0;
    rsp_valid  = 1'b0;
    case (state_reg)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_next = EXEC;
      end
      // ALU result settles from the registered operands during this cycle.
      EXEC: state_next = RESP;
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // ---------------- Register file ----------------
  // Entry 0 has no write enable, so it keeps its reset value of zero forever.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_wen
      if (gi == 0) begin : g_zero
        assign wr_en[gi] = 1'b0;
      end else begin : g_wr
        assign wr_en[gi] = (state_reg == EXEC) && (rd_reg == REG_AW'(gi));
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) rf_reg[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wr_en[i]) rf_reg[i] <= alu_res;
      end
    end
  end

  // ---------------- Datapath ----------------
  // Operands only move on acceptance, so the ALU inputs stay frozen through
  // EXEC and RESP; response fields only move at the end of EXEC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a    <= '0;
      alu_b    <= '0;
      alu_op   <= '0;
      rd_reg   <= '0;
      rsp_data <= '0;
      rsp_rd   <= '0;
      rsp_zero <= 1'b0;
    end else begin
      if (cmd_fire) begin
        alu_a  <= rf_reg[cmd_rs1];
        alu_b  <= cmd_use_imm ? cmd_imm : rf_reg[cmd_rs2];
        alu_op <= cmd_op;
        rd_reg <= cmd_rd;
      end
      if (state_reg == EXEC) begin
        rsp_data <= alu_res;
        rsp_zero <= (alu_res == '0);
        rsp_rd   <= rd_reg;
      end
    end
  end

endmodule

// File: tb/tb_alu_cmd_driver.sv
module tb_alu_cmd_driver;

  localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, SLL = 3'd2, LSR = 3'd3,
                         AND_ = 3'd4, OR_ = 3'd5, XOR_ = 3'd6, EQL = 3'd7;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid, cmd_ready;
  logic [2:0] cmd_op;
  logic [1:0] cmd_rd, cmd_rs1, cmd_rs2;
  logic       cmd_use_imm;
  logic [7:0] cmd_imm;
  logic [7:0] alu_a, alu_b, alu_res;
  logic [2:0] alu_op;
  logic       rsp_valid, rsp_ready;
  logic [7:0] rsp_data;
  logic [1:0] rsp_rd;
  logic       rsp_zero;

  int total = 0;
  int bad   = 0;

  // Reference register file.
  logic [7:0] mrf [4];

  always #5 clk = ~clk;

  // Arithmetic rules of the ALU, straight from the opcode table.
  function automatic logic [7:0] alu_fn(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      ADD:     return a + b;
      SUB:     return a - b;
      SLL:     return (b >= 8) ? 8'h00 : 8'(a << b);
      LSR:     return (b >= 8) ? 8'h00 : 8'(a >> b);
      AND_:    return a & b;
      OR_:     return a | b;
      XOR_:    return a ^ b;
      default: return (a == b) ? 8'h01 : 8'h00;
    endcase
  endfunction

  // External combinational ALU.
  assign alu_res = alu_fn(alu_op, alu_a, alu_b);

  alu_cmd_driver #(.DATA_W(8), .NUM_REGS(4), .REG_AW(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_rd(cmd_rd),
    .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2), .cmd_use_imm(cmd_use_imm), .cmd_imm(cmd_imm),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_res(alu_res),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_rd(rsp_rd), .rsp_zero(rsp_zero)
  );

  // Reference: operand values from the model register file, result per ALU
  // rules, write-back unless rd is r0.
  function automatic logic [7:0] op_b(input logic [1:0] rs2, input logic ui, input logic [7:0] imm);
    return ui ? imm : mrf[rs2];
  endfunction

  function automatic logic [7:0] model_exec(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                                            input logic [1:0] rs2, input logic ui, input logic [7:0] imm);
    logic [7:0] r;
    r = alu_fn(op, mrf[rs1], op_b(rs2, ui, imm));
    if (rd != 2'd0) mrf[rd] = r;
    return r;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 4; i++) mrf[i] = 8'h00;
  endtask

  // Drives one command starting just after a rising edge with the DUT idle,
  // waits (bounded) for the response, handshakes it and returns what was seen.
  // wait_n = cycles cmd_ready was low before acceptance; lat = edges from the
  // accepting edge to rsp_valid being seen (-1 on timeout).
  task automatic run_cmd(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                         input logic [1:0] rs2, input logic ui, input logic [7:0] imm,
                         output logic [7:0] d, output logic [1:0] r, output logic z, output int lat,
                         output int wait_n, output logic [7:0] a, output logic [7:0] b, output logic [2:0] o);
    cmd_op = op; cmd_rd = rd; cmd_rs1 = rs1; cmd_rs2 = rs2; cmd_use_imm = ui; cmd_imm = imm;
    cmd_valid = 1'b1; rsp_ready = 1'b1;
    wait_n = 0; lat = -1;
    @(negedge clk);
    while (!cmd_ready && wait_n < 20) begin @(negedge clk); wait_n++; end
    if (cmd_ready) begin
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      // Scribble over the fields; they must have no effect now.
      cmd_op = 3'($urandom); cmd_rd = 2'($urandom); cmd_rs1 = 2'($urandom);
      cmd_rs2 = 2'($urandom); cmd_use_imm = 1'($urandom); cmd_imm = 8'($urandom);
      lat = 0;
      do begin @(posedge clk); lat++; @(negedge clk); end while (!rsp_valid && lat < 20);
      if (!rsp_valid) lat = -1;
    end else begin
      cmd_valid = 1'b0;
    end
    d = rsp_data; r = rsp_rd; z = rsp_zero; a = alu_a; b = alu_b; o = alu_op;
    $display("txn op=%0d rd=%0d rs1=%0d rs2=%0d imm=%0d use_imm=%0d -> data=%02h rd=%0d zero=%0d lat=%0d",
             op, rd, rs1, rs2, imm, ui, d, r, z, lat);
    @(posedge clk); #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0;
    cmd_op = '0; cmd_rd = '0; cmd_rs1 = '0; cmd_rs2 = '0; cmd_use_imm = 1'b0; cmd_imm = '0;
    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // -------------------------------------------------------------------------
  task automatic test_reset();
    rst_n = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0;
    cmd_op = '0; cmd_rd = '0; cmd_rs1 = '0; cmd_rs2 = '0; cmd_use_imm = 1'b0; cmd_imm = '0;
    model_clear();
    repeat (2) @(posedge clk); #1;
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%b want=0", rsp_valid); end
    total++; if ({alu_a, alu_b, alu_op} !== 19'd0) begin bad++; $display("FAIL reset_alu got=%h/%h/%h want=0", alu_a, alu_b, alu_op); end
    total++; if ({rsp_data, rsp_rd, rsp_zero} !== 11'd0) begin bad++; $display("FAIL reset_rsp got=%h/%h/%b want=0", rsp_data, rsp_rd, rsp_zero); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_cmd_ready got=%b want=1", cmd_ready); end
  endtask

  task automatic test_basic();
    logic [7:0] d, a, b; logic [1:0] r; logic z; logic [2:0] o; int lat, wn;
    void'(model_exec(ADD, 2'd1, 2'd0, 2'd0, 1'b1, 8'h05));
    run_cmd(ADD, 2'd1, 2'd0, 2'd0, 1'b1, 8'h05, d, r, z, lat, wn, a, b, o);
    total++; if (lat !== 1) begin bad++; $display("FAIL add_latency got=%0d want=1", lat); end
    total++; if (d !== 8'h05) begin bad++; $display("FAIL add_data got=%h want=05", d); end
    total++; if (r !== 2'd1) begin bad++; $display("FAIL add_rd got=%0d want=1", r); end
    total++; if (z !== 1'b0) begin bad++; $display("FAIL add_zero got=%b want=0", z); end
    total++; if ({a, b, o} !== {8'h00, 8'h05, ADD}) begin bad++; $display("FAIL add_alu got=%h/%h/%h want=00/05/0", a, b, o); end

    void'(model_exec(ADD, 2'd2, 2'd1, 2'd0, 1'b1, 8'hFF));
    run_cmd(ADD, 2'd2, 2'd1, 2'd0, 1'b1, 8'hFF, d, r, z, lat, wn, a, b, o);
    total++; if (d !== 8'h04) begin bad++; $display("FAIL add_wrap_data got=%h want=04", d); end

    void'(model_exec(SUB, 2'd3, 2'd1, 2'd1, 1'b0, 8'h00));
    run_cmd(SUB, 2'd3, 2'd1, 2'd1, 1'b0, 8'hA5, d, r, z, lat, wn, a, b, o);
    total++; if ({d, z} !== {8'h00, 1'b1}) begin bad++; $display("FAIL sub_data got=%h z=%b want=00 z=1", d, z); end
    total++; if ({a, b} !== {8'h05, 8'h05}) begin bad++; $display("FAIL sub_operands got=%h/%h want=05/05", a, b); end

    void'(model_exec(EQL, 2'd3, 2'd1, 2'd1, 1'b0, 8'h00));
    run_cmd(EQL, 2'd3, 2'd1, 2'd1, 1'b0, 8'h00, d, r, z, lat, wn, a, b, o);
    total++; if ({d, z, r} !== {8'h01, 1'b0, 2'd3}) begin bad++; $display("FAIL eql_data got=%h z=%b rd=%0d want=01 z=0 rd=3", d, z, r); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] d, a, b; logic [1:0] r; logic z; logic [2:0] o; int lat, wn;
    void'(model_exec(SLL, 2'd1, 2'd1, 2'd0, 1'b1, 8'd1));
    run_cmd(SLL, 2'd1, 2'd1, 2'd0, 1'b1, 8'd1, d, r, z, lat, wn, a, b, o);
    total++; if (d !== 8'h0A) begin bad++; $display("FAIL sll_data got=%h want=0a", d); end
    void'(model_exec(LSR, 2'd1, 2'd1, 2'd0, 1'b1, 8'd9));
    run_cmd(LSR, 2'd1, 2'd1, 2'd0, 1'b1, 8'd9, d, r, z, lat, wn, a, b, o);
    total++; if (wn !== 0) begin bad++; $display("FAIL b2b_ready_wait got=%0d want=0", wn); end
    total++; if (a !== 8'h0A) begin bad++; $display("FAIL b2b_dep_operand got=%h want=0a", a); end
    total++; if ({d, z} !== {8'h00, 1'b1}) begin bad++; $display("FAIL lsr_data got=%h z=%b want=00 z=1", d, z); end
  endtask

  task automatic test_backpressure();
    logic [7:0] d, a, b; logic [1:0] r; logic z; logic [2:0] o; int lat, wn;
    logic [7:0] a1, exp1, exp2;
    // Seed r1 with something non-trivial first.
    void'(model_exec(ADD, 2'd1, 2'd0, 2'd0, 1'b1, 8'h21));
    run_cmd(ADD, 2'd1, 2'd0, 2'd0, 1'b1, 8'h21, d, r, z, lat, wn, a, b, o);
    a1 = mrf[1];
    exp1 = model_exec(ADD, 2'd2, 2'd1, 2'd0, 1'b1, 8'h10);
    exp2 = model_exec(XOR_, 2'd3, 2'd2, 2'd1, 1'b0, 8'h00);
    cmd_op = ADD; cmd_rd = 2'd2; cmd_rs1 = 2'd1; cmd_rs2 = 2'd0; cmd_use_imm = 1'b1; cmd_imm = 8'h10;
    cmd_valid = 1'b1; rsp_ready = 1'b0;
    @(posedge clk); #1;
    // Second command presented immediately and held.
    cmd_op = XOR_; cmd_rd = 2'd3; cmd_rs1 = 2'd2; cmd_rs2 = 2'd1; cmd_use_imm = 1'b0; cmd_imm = 8'hEE;
    @(posedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++; if ({rsp_valid, cmd_ready} !== 2'b10) begin bad++; $display("FAIL bp_hold_flags cyc=%0d got=%b%b want=10", i, rsp_valid, cmd_ready); end
      total++; if ({rsp_data, rsp_rd} !== {exp1, 2'd2}) begin bad++; $display("FAIL bp_hold_rsp cyc=%0d got=%h/%0d want=%h/2", i, rsp_data, rsp_rd, exp1); end
      total++; if ({alu_a, alu_b, alu_op} !== {a1, 8'h10, ADD}) begin bad++; $display("FAIL bp_hold_alu cyc=%0d got=%h/%h/%h want=%h/10/0", i, alu_a, alu_b, alu_op, a1); end
      @(posedge clk);
    end
    #1 rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    total++; if ({rsp_valid, cmd_ready} !== 2'b01) begin bad++; $display("FAIL bp_after_hs got=%b%b want=01", rsp_valid, cmd_ready); end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(negedge clk);
    total++; if ({cmd_ready, alu_a, alu_b, alu_op} !== {1'b0, exp1, a1, XOR_}) begin bad++; $display("FAIL bp_second_accept got=%b/%h/%h/%h want=0/%h/%h/6", cmd_ready, alu_a, alu_b, alu_op, exp1, a1); end
    lat = 0;
    while (!rsp_valid && lat < 20) begin @(negedge clk); lat++; end
    total++; if ({rsp_valid, rsp_data, rsp_rd} !== {1'b1, exp2, 2'd3}) begin bad++; $display("FAIL bp_second_rsp got=%b/%h/%0d want=1/%h/3", rsp_valid, rsp_data, rsp_rd, exp2); end
    @(posedge clk); #1;
  endtask

  task automatic test_r0();
    logic [7:0] d, a, b; logic [1:0] r; logic z; logic [2:0] o; int lat, wn;
    void'(model_exec(ADD, 2'd0, 2'd0, 2'd0, 1'b1, 8'h07));
    run_cmd(ADD, 2'd0, 2'd0, 2'd0, 1'b1, 8'h07, d, r, z, lat, wn, a, b, o);
    total++; if ({d, r} !== {8'h07, 2'd0}) begin bad++; $display("FAIL r0_write_rsp got=%h/%0d want=07/0", d, r); end
    void'(model_exec(OR_, 2'd1, 2'd0, 2'd0, 1'b0, 8'h00));
    run_cmd(OR_, 2'd1, 2'd0, 2'd0, 1'b0, 8'h3C, d, r, z, lat, wn, a, b, o);
    total++; if ({d, z} !== {8'h00, 1'b1}) begin bad++; $display("FAIL r0_read got=%h z=%b want=00 z=1", d, z); end
  endtask

  task automatic test_random();
    logic [7:0] d, a, b; logic [1:0] r; logic z; logic [2:0] o; int lat, wn;
    logic [2:0] op; logic [1:0] rd, rs1, rs2; logic ui; logic [7:0] imm, ea, eb, ed;
    for (int n = 0; n < 40; n++) begin
      op = 3'($urandom); rd = 2'($urandom); rs1 = 2'($urandom); rs2 = 2'($urandom);
      ui = 1'($urandom); imm = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 10)) : 8'($urandom);
      ea = mrf[rs1]; eb = op_b(rs2, ui, imm);
      ed = model_exec(op, rd, rs1, rs2, ui, imm);
      run_cmd(op, rd, rs1, rs2, ui, imm, d, r, z, lat, wn, a, b, o);
      total++; if ({d, r, z} !== {ed, rd, ed == 8'h00}) begin bad++; $display("FAIL rand_rsp n=%0d got=%h/%0d/%b want=%h/%0d/%b", n, d, r, z, ed, rd, ed == 8'h00); end
      total++; if ({a, b, o} !== {ea, eb, op}) begin bad++; $display("FAIL rand_alu n=%0d got=%h/%h/%h want=%h/%h/%h", n, a, b, o, ea, eb, op); end
      total++; if (lat !== 1) begin bad++; $display("FAIL rand_latency n=%0d got=%0d want=1", n, lat); end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] d, a, b; logic [1:0] r; logic z; logic [2:0] o; int lat, wn;
    void'(model_exec(ADD, 2'd1, 2'd0, 2'd0, 1'b1, 8'h33));
    run_cmd(ADD, 2'd1, 2'd0, 2'd0, 1'b1, 8'h33, d, r, z, lat, wn, a, b, o);
    total++; if (d !== 8'h33) begin bad++; $display("FAIL midrst_seed got=%h want=33", d); end
    cmd_op = ADD; cmd_rd = 2'd2; cmd_rs1 = 2'd1; cmd_use_imm = 1'b1; cmd_imm = 8'h01;
    cmd_valid = 1'b1; rsp_ready = 1'b1;
    @(posedge clk); #1 cmd_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++; if ({rsp_valid, cmd_ready} !== 2'b01) begin bad++; $display("FAIL midrst_flags got=%b%b want=01", rsp_valid, cmd_ready); end
    total++; if ({alu_a, alu_b, alu_op, rsp_data, rsp_rd, rsp_zero} !== 30'd0) begin bad++; $display("FAIL midrst_outputs got=%h/%h/%h/%h/%h/%b want=0", alu_a, alu_b, alu_op, rsp_data, rsp_rd, rsp_zero); end
    model_clear();
    @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL midrst_no_rsp cyc=%0d got=%b want=0", i, rsp_valid); end
    end
    @(posedge clk); #1;
    void'(model_exec(ADD, 2'd1, 2'd1, 2'd0, 1'b1, 8'h00));
    run_cmd(ADD, 2'd1, 2'd1, 2'd0, 1'b1, 8'h00, d, r, z, lat, wn, a, b, o);
    total++; if ({d, z} !== {8'h00, 1'b1}) begin bad++; $display("FAIL midrst_rf_cleared got=%h z=%b want=00 z=1", d, z); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_backpressure();
    test_r0();
    test_random();
    test_reset_mid();
    apply_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard stop in case something wedges outside the bounded waits.
  initial begin
    #200000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1, "timeout");
  end

endmodule
